// File: rtl/seq_scan_ctrl.sv
// Scan controller: serialises a captured word MSB-first and runs a programmable
// Mealy pattern detector over it, collecting match count and first-match position.
module seq_scan_ctrl #(
  parameter int WIDTH   = 16,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               busy,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               match_pulse,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic [CNT_W-1:0]   first_pos,
  output logic               found
);

  localparam int                HIST_W   = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
  localparam int                FILL_W   = $clog2(PAT_LEN) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_K   = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_word;
  logic [PAT_LEN-1:0] r_pat;
  logic               r_ovl;
  logic [HIST_W-1:0]  r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_k;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_first;
  logic               r_found;

  logic               w_shift;
  logic               w_ser_bit;
  logic [PAT_LEN-1:0] w_window;
  logic               w_match;

  assign w_shift   = (r_state == S_SHIFT);
  assign w_ser_bit = w_shift & r_word[WIDTH-1];

  // Window = last PAT_LEN-1 history bits followed by the bit on the wire now.
  if (PAT_LEN > 1) begin : g_window
    assign w_window = {r_hist, w_ser_bit};
  end else begin : g_window_1
    assign w_window = w_ser_bit;
  end

  assign w_match = w_shift && (r_fill == FILL_MAX) && (w_window == r_pat);

  assign busy        = w_shift;
  assign ser_valid   = w_shift;
  assign ser_bit     = w_ser_bit;
  assign match_pulse = w_match;
  assign done        = (r_state == S_DONE);
  assign match_count = r_count;
  assign first_pos   = r_first;
  assign found       = r_found;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_k == LAST_K) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word  <= '0;
      r_pat   <= '0;
      r_ovl   <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_k     <= '0;
      r_count <= '0;
      r_first <= '0;
      r_found <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_word  <= data_in;
        r_pat   <= pattern;
        r_ovl   <= overlap;
        r_hist  <= '0;
        r_fill  <= '0;
        r_k     <= '0;
        r_count <= '0;
        r_first <= '0;
        r_found <= 1'b0;
      end
    end else if (w_shift) begin
      r_word <= r_word << 1;
      r_k    <= r_k + 1'b1;
      if (w_match) begin
        r_count <= r_count + 1'b1;
        if (!r_found) begin
          r_first <= r_k;
          r_found <= 1'b1;
        end
      end
      // Non-overlapping match discards the history so the next match needs
      // PAT_LEN fresh bits; otherwise history slides and the fill saturates.
      if (w_match && !r_ovl) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= HIST_W'(w_window);
        if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a vector table of whole scans plus
// hand-written sequences for ignored inputs and asynchronous reset mid-scan.
module tb_seq_scan_ctrl;

  localparam int WIDTH   = 16;
  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [PAT_LEN-1:0] pattern;
  logic               overlap;
  logic               busy;
  logic               ser_bit;
  logic               ser_valid;
  logic               match_pulse;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic [CNT_W-1:0]   first_pos;
  logic               found;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_scan_ctrl #(.WIDTH(WIDTH), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .pattern    (pattern),
    .overlap    (overlap),
    .busy       (busy),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .match_pulse(match_pulse),
    .done       (done),
    .match_count(match_count),
    .first_pos  (first_pos),
    .found      (found)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [WIDTH-1:0]   data;
    logic [PAT_LEN-1:0] pat;
    logic               ovl;
    logic [WIDTH-1:0]   exp_mask;
    int                 exp_count;
    int                 exp_first;
    logic               exp_found;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one scan from the start edge through the IDLE cycle after done.
  // Returns with time in cycle WIDTH+2 (IDLE), results still held.
  task automatic do_scan(input logic [WIDTH-1:0] d, input logic [PAT_LEN-1:0] p,
                         input logic o, input logic keep_start,
                         output logic [WIDTH-1:0] mask, output logic [WIDTH-1:0] word,
                         output int bad, output int done_cyc);
    mask = '0;
    word = '0;
    bad = 0;
    done_cyc = -1;
    @(negedge clk);
    data_in = d;
    pattern = p;
    overlap = o;
    start   = 1'b1;
    for (int c = 1; c <= WIDTH + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (keep_start) begin
          data_in = ~d;
          pattern = ~p;
          overlap = ~o;
        end else begin
          start = 1'b0;
        end
      end
      if (c <= WIDTH) begin
        if (!busy || !ser_valid) bad++;
        mask[c-1]     = match_pulse;
        word[WIDTH-c] = ser_bit;
      end else if (busy || ser_valid || match_pulse || ser_bit) begin
        bad++;
      end
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        else bad++;
      end
    end
  endtask

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] word;
  int               bad;
  int               done_cyc;
  int               done_seen;

  initial begin
    vecs[0] = '{"single",    16'hB000, 4'b1011, 1'b1, 16'h0008,  1,  3, 1'b1};
    vecs[1] = '{"b600_ovl",  16'hB600, 4'b1011, 1'b1, 16'h0048,  2,  3, 1'b1};
    vecs[2] = '{"b600_novl", 16'hB600, 4'b1011, 1'b0, 16'h0008,  1,  3, 1'b1};
    vecs[3] = '{"ones_ovl",  16'hFFFF, 4'b1111, 1'b1, 16'hFFF8, 13,  3, 1'b1};
    vecs[4] = '{"ones_novl", 16'hFFFF, 4'b1111, 1'b0, 16'h8888,  4,  3, 1'b1};
    vecs[5] = '{"zero",      16'h0000, 4'b1011, 1'b1, 16'h0000,  0,  0, 1'b0};
    vecs[6] = '{"alt_ovl",   16'hAAAA, 4'b1010, 1'b1, 16'hAAA8,  7,  3, 1'b1};
    vecs[7] = '{"alt_novl",  16'hAAAA, 4'b1010, 1'b0, 16'h8888,  4,  3, 1'b1};
    vecs[8] = '{"last_bit",  16'h000B, 4'b1011, 1'b0, 16'h8000,  1, 15, 1'b1};

    reset   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    pattern = '0;
    overlap = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, ser_valid}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_first", 32'(first_pos), 32'd0);
    check("rst_found", {31'd0, found}, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      do_scan(vecs[i].data, vecs[i].pat, vecs[i].ovl, 1'b0, mask, word, bad, done_cyc);
      check({vecs[i].name, "_mask"},  32'(mask), 32'(vecs[i].exp_mask));
      check({vecs[i].name, "_ser"},   32'(word), 32'(vecs[i].data));
      check({vecs[i].name, "_hs"},    32'(bad), 32'd0);
      check({vecs[i].name, "_done"},  32'(done_cyc), 32'(WIDTH + 1));
      check({vecs[i].name, "_count"}, 32'(match_count), 32'(vecs[i].exp_count));
      check({vecs[i].name, "_first"}, 32'(first_pos), 32'(vecs[i].exp_first));
      check({vecs[i].name, "_found"}, {31'd0, found}, {31'd0, vecs[i].exp_found});
    end

    // start held high with inputs changing: scan must use captured values only.
    do_scan(16'hB000, 4'b1011, 1'b1, 1'b1, mask, word, bad, done_cyc);
    check("hold_mask",  32'(mask), 32'h0008);
    check("hold_ser",   32'(word), 32'hB000);
    check("hold_hs",    32'(bad), 32'd0);
    check("hold_done",  32'(done_cyc), 32'(WIDTH + 1));
    check("hold_count", 32'(match_count), 32'd1);
    // Still-high start is taken from IDLE: second scan of 4FFF / 0100 non-overlap.
    @(negedge clk);
    start = 1'b0;
    check("rescan_busy",  {31'd0, busy}, 32'd1);
    check("rescan_clear", 32'(match_count), 32'd0);
    repeat (WIDTH + 1) @(negedge clk);
    check("rescan_count", 32'(match_count), 32'd1);
    check("rescan_first", 32'(first_pos), 32'd3);
    check("rescan_idle",  {31'd0, busy}, 32'd0);

    // Asynchronous reset in cycle 8 of an all-ones overlapping scan.
    @(negedge clk);
    data_in = 16'hFFFF;
    pattern = 4'b1111;
    overlap = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_count", 32'(match_count), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("arst_busy",  {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, ser_valid}, 32'd0);
    check("arst_count", 32'(match_count), 32'd0);
    check("arst_found", {31'd0, found}, 32'd0);
    check("arst_done",  {31'd0, done}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    do_scan(16'hB600, 4'b1011, 1'b1, 1'b0, mask, word, bad, done_cyc);
    check("post_rst_mask",  32'(mask), 32'h0048);
    check("post_rst_done",  32'(done_cyc), 32'(WIDTH + 1));
    check("post_rst_count", 32'(match_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Controller that sequences a programmable-pattern Mealy sequence detector over a parallel data word.
- Accepts a WIDTH-bit word plus a PAT_LEN-bit pattern on a start pulse, serialises the word MSB-first one bit per clock, and detects the pattern in either overlapping or non-overlapping mode.
- Reports a per-bit match pulse, total match count, position of the first match and a done pulse.
- Sits in front of the serial detector path and owns its bit scheduling and result collection.

Parameters:
- WIDTH, 16, data word length in bits; must satisfy PAT_LEN <= WIDTH.
- PAT_LEN, 4, pattern length in bits; must be >= 1.
- CNT_W, 5, width of match_count and first_pos; must be >= clog2(WIDTH+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to scan; sampled only in IDLE.
- data_in  input  WIDTH  word to scan; bit WIDTH-1 is shifted first.
- pattern  input  PAT_LEN  pattern to detect; bit PAT_LEN-1 is the first expected bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- busy  output  1  high throughout SHIFT.
- ser_bit  output  1  current serial bit; 0 when ser_valid = 0.
- ser_valid  output  1  high while a serial bit is presented (SHIFT).
- match_pulse  output  1  Mealy output: high in the cycle whose ser_bit completes the pattern.
- done  output  1  one-cycle pulse after the last bit.
- match_count  output  CNT_W  number of matches in the last/current scan.
- first_pos  output  CNT_W  0-based bit index of the completing bit of the first match.
- found  output  1  at least one match in the last/current scan.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - All outputs and internal registers (shift reg, history, fill counter, bit index, captured pattern/overlap) clear to 0.
  - Reset takes effect immediately, including mid-SHIFT or in DONE; an aborted scan produces no done pulse.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on rising clk with start = 1, capture data_in, pattern and overlap. Clear match_count, first_pos, found, the history register and the fill counter. Go to SHIFT.
  - SHIFT: lasts exactly WIDTH cycles, bit index k = 0..WIDTH-1.
    - ser_valid = 1, busy = 1, ser_bit = captured word bit WIDTH-1-k.
    - After k = WIDTH-1, go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, then go to IDLE.
- Start behaviour:
  - start is ignored in SHIFT and DONE.
  - Changes to data_in, pattern or overlap after capture have no effect on the running scan.
- Latency: start accepted at edge 0; bits presented in cycles 1..WIDTH; done in cycle WIDTH+1. The earliest next start is accepted at the end of the done cycle's following edge (IDLE).
- Detection:
  - The history register holds the last PAT_LEN-1 shifted bits.
  - The fill counter saturates at PAT_LEN-1.
  - match_pulse = ser_valid AND (fill counter == PAT_LEN-1) AND ({history, ser_bit} == captured pattern). This is combinational from registered state and the current bit.
- On a match (clock edge):
  - match_count increments (cannot overflow given the CNT_W rule).
  - If found = 0: first_pos <= k and found <= 1.
  - Non-overlap mode: the fill counter and history reset to 0, so the next match needs PAT_LEN fresh bits.
  - Overlap mode: the fill counter stays saturated and history shifts normally.
- Results (match_count, first_pos, found) update live during SHIFT. They hold stable from DONE until the next accepted start.
- No match: found = 0 and first_pos = 0.

Test Plan:
1. Single match: WIDTH = 16, pattern 4'b1011, overlap = 1, data_in 16'hB000, start pulse at cycle 0 → busy in cycles 1–16; match_pulse only in cycle 4 (k = 3); done in cycle 17; match_count = 1, first_pos = 3, found = 1.
2. Overlap vs non-overlap: data_in 16'hB600, pattern 1011.
   - overlap = 1 → matches at k = 3 and 6; match_count = 2, first_pos = 3.
   - overlap = 0 → match_count = 1, first_pos = 3.
3. All ones: data_in 16'hFFFF, pattern 4'b1111.
   - overlap = 1 → match_count = 13 (k = 3..15).
   - overlap = 0 → match_count = 4 (k = 3, 7, 11, 15).
4. No match: data_in 16'h0000, pattern 1011 → match_pulse never high; match_count = 0, found = 0, first_pos = 0; done in cycle 17.
5. Ignored inputs: start at cycle 0, then start = 1 continuously plus pattern/data_in changes during cycles 1–17 → exactly one scan with the captured values; a second scan begins only after returning to IDLE.
6. Reset mid-operation: assert reset = 0 at cycle 8 of a scan → busy, ser_valid, match_count, found and done go to 0 immediately without waiting for clk; no done pulse; a fresh start after release scans normally.
